// File: rtl/dlfloat_pkg.sv
// rtl/dlfloat_pkg.sv - DLFloat16 types, constants, FSM states and result packing (DLFLOAT_SAT_EN)
package dlfloat_pkg;

    typedef logic [15:0] dlfloat16_t;

    localparam int         EXP_W    = 6;
    localparam int         MAN_W    = 9;
    localparam int         BIAS     = 31;
    localparam dlfloat16_t DLF_ZERO = 16'h0000;
    localparam logic [14:0] DLF_MAX = 15'h7FFF;

    typedef enum logic [1:0] {IDLE, MUL, ACC, OUT} state_t;

    // Exponent arrives unbiased-range checked here so both product and sum share flush/overflow.
    function automatic dlfloat16_t dlf_pack(input logic s, input logic signed [9:0] e,
                                            input logic [MAN_W-1:0] m);
        dlfloat16_t r;
        if (e < 10'sd1) begin
            r = DLF_ZERO;
        end else if (e > 10'sd63) begin
`ifdef DLFLOAT_SAT_EN
            r = {s, DLF_MAX};
`else
            r = {s, e[EXP_W-1:0], m};
`endif
        end else begin
            r = {s, e[EXP_W-1:0], m};
        end
        return r;
    endfunction

endpackage

// File: rtl/dlfloat_add_comb.sv
// rtl/dlfloat_add_comb.sv - combinational DLFloat16 adder with truncating alignment
module dlfloat_add_comb
    import dlfloat_pkg::*;
(
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_y
);

    logic               w_swap;
    logic [15:0]        w_big;
    logic [15:0]        w_small;
    logic [5:0]         w_d;
    logic [9:0]         w_mb;
    logic [9:0]         w_ms;
    logic [10:0]        w_sum;
    logic [9:0]         w_diff;
    logic [9:0]         w_norm;
    logic [3:0]         w_lz;
    logic signed [9:0]  w_eb;

    always_comb begin
        o_y     = DLF_ZERO;
        w_swap  = (i_b[14:0] > i_a[14:0]);
        w_big   = w_swap ? i_b : i_a;
        w_small = w_swap ? i_a : i_b;
        w_d     = w_big[14:9] - w_small[14:9];
        w_mb    = {1'b1, w_big[8:0]};
        w_ms    = {1'b1, w_small[8:0]} >> w_d;
        w_eb    = $signed({4'b0, w_big[14:9]});
        w_sum   = {1'b0, w_mb} + {1'b0, w_ms};
        w_diff  = w_mb - w_ms;
        w_lz    = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (w_diff[i]) w_lz = 4'(9 - i);
        end
        w_norm  = w_diff << w_lz;

        if (i_a == DLF_ZERO) begin
            o_y = i_b;
        end else if (i_b == DLF_ZERO) begin
            o_y = i_a;
        end else if (i_a[15] == i_b[15]) begin
            if (w_sum[10]) o_y = dlf_pack(w_big[15], w_eb + 10'sd1, w_sum[9:1]);
            else           o_y = dlf_pack(w_big[15], w_eb, w_sum[8:0]);
        end else if (w_diff != 10'd0) begin
            o_y = dlf_pack(w_big[15], w_eb - $signed({6'b0, w_lz}), w_norm[8:0]);
        end
    end

endmodule

// File: rtl/dlfloat_vmac.sv
// rtl/dlfloat_vmac.sv - multi-lane DLFloat16 dot-product MAC; DLFLOAT_SAT_EN selects overflow saturation
module dlfloat_vmac
    import dlfloat_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [16*LANES-1:0]  in_a,
    input  logic [16*LANES-1:0]  in_b,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          out_data,
    output logic [7:0]           out_beats
);

    state_t               r_state;
    state_t               w_next;
    logic [16*LANES-1:0]  r_a;
    logic [16*LANES-1:0]  r_b;
    logic [16*LANES-1:0]  r_prod;
    logic [16*LANES-1:0]  w_prod;
    logic                 r_last;
    logic [3:0]           r_idx;
    dlfloat16_t           r_acc;
    dlfloat16_t           w_sum;
    dlfloat16_t           w_lane;
    logic [7:0]           r_beats;

    function automatic dlfloat16_t dlf_mul(input dlfloat16_t a, input dlfloat16_t b);
        logic [19:0]       p;
        logic signed [9:0] e;
        dlfloat16_t        r;
        p = {1'b1, a[8:0]} * {1'b1, b[8:0]};
        e = $signed({4'b0, a[14:9]}) + $signed({4'b0, b[14:9]}) - 10'sd31;
        if (a == DLF_ZERO || b == DLF_ZERO) r = DLF_ZERO;
        else if (p[19])                     r = dlf_pack(a[15] ^ b[15], e + 10'sd1, p[18:10]);
        else                                r = dlf_pack(a[15] ^ b[15], e, p[17:9]);
        return r;
    endfunction

    always_comb begin
        w_prod = '0;
        w_lane = DLF_ZERO;
        for (int i = 0; i < LANES; i++) begin
            w_prod[16*i +: 16] = dlf_mul(r_a[16*i +: 16], r_b[16*i +: 16]);
            if (r_idx == 4'(i)) w_lane = r_prod[16*i +: 16];
        end
    end

    dlfloat_add_comb u_add (
        .i_a (r_acc),
        .i_b (w_lane),
        .o_y (w_sum)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = MUL;
            MUL:     w_next = ACC;
            ACC:     if (r_idx == 4'(LANES - 1)) w_next = r_last ? OUT : IDLE;
            OUT:     if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_prod  <= '0;
            r_last  <= 1'b0;
            r_idx   <= 4'd0;
            r_acc   <= DLF_ZERO;
            r_beats <= 8'd0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_a    <= in_a;
                    r_b    <= in_b;
                    r_last <= in_last;
                    if (r_beats != 8'hFF) r_beats <= r_beats + 8'd1;
                end
                MUL: begin
                    r_prod <= w_prod;
                    r_idx  <= 4'd0;
                end
                ACC: begin
                    r_acc <= w_sum;
                    r_idx <= r_idx + 4'd1;
                end
                OUT: if (out_ready) begin
                    r_acc   <= DLF_ZERO;
                    r_beats <= 8'd0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == OUT);
    assign out_data  = out_valid ? r_acc : DLF_ZERO;
    assign out_beats = out_valid ? r_beats : 8'd0;

endmodule
